// File: rtl/multdiv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : multdiv_ctrl_pkg
// Purpose : Shared state encoding and ISA status constants for the multdiv
//           execute-stage sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package multdiv_ctrl_pkg;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_BUSY  = 2'd2;
    localparam logic [1:0] c_ST_WB    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = c_ST_IDLE,
        ST_START = c_ST_START,
        ST_BUSY  = c_ST_BUSY,
        ST_WB    = c_ST_WB
    } state_e;

    localparam int c_TIMEOUT       = 40;
    localparam int c_CNT_WIDTH     = 6;
    localparam int c_RSTATUS_REG   = 30;
    localparam int c_MUL_EXC_CODE  = 4;
    localparam int c_DIV_EXC_CODE  = 5;

endpackage
`default_nettype wire

// File: rtl/multdiv_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : multdiv_ctrl_if
// Purpose : Execute-stage request, multdiv handshake and writeback bundle.
// Revision: 1.0 - initial release
// ============================================================================
interface multdiv_ctrl_if;

    logic        ex_is_mult;
    logic        ex_is_div;
    logic [31:0] ex_opA;
    logic [31:0] ex_opB;
    logic [4:0]  ex_rd;

    logic [31:0] md_operandA;
    logic [31:0] md_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_resultRDY;

    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_exception;

    // master is the sequencer; slave is the pipeline/multdiv environment
    modport master (
        input  ex_is_mult, ex_is_div, ex_opA, ex_opB, ex_rd,
        input  md_result, md_exception, md_resultRDY,
        output md_operandA, md_operandB, ctrl_MULT, ctrl_DIV,
        output stall, wb_valid, wb_rd, wb_data, wb_exception
    );

    modport slave (
        output ex_is_mult, ex_is_div, ex_opA, ex_opB, ex_rd,
        output md_result, md_exception, md_resultRDY,
        input  md_operandA, md_operandB, ctrl_MULT, ctrl_DIV,
        input  stall, wb_valid, wb_rd, wb_data, wb_exception
    );

endinterface
`default_nettype wire

// File: rtl/multdiv_ctrl_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module  : md_timeout_counter
// Purpose : Synchronous up-counter with clear/enable; flags the last allowed
//           BUSY cycle (count == TIMEOUT-1).
// Revision: 1.0 - initial release
// ============================================================================
module md_timeout_counter #(
    parameter int TIMEOUT = 40,
    parameter int WIDTH   = 6
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_clr,
    input  wire logic i_en,
    output logic      o_terminal
);

    localparam logic [WIDTH-1:0] c_TERMINAL = WIDTH'(TIMEOUT - 1);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_terminal = (r_count == c_TERMINAL);

endmodule
`default_nettype wire

// File: rtl/multdiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : multdiv_ctrl
// Purpose : Execute-stage sequencer for the multdiv unit: captures operands,
//           pulses start, stalls until ready/timeout, emits one writeback.
// Revision: 1.0 - initial release
// ============================================================================
module multdiv_ctrl
    import multdiv_ctrl_pkg::*;
#(
    parameter int TIMEOUT      = c_TIMEOUT,
    parameter int RSTATUS_REG  = c_RSTATUS_REG,
    parameter int MUL_EXC_CODE = c_MUL_EXC_CODE,
    parameter int DIV_EXC_CODE = c_DIV_EXC_CODE
) (
    input  wire logic      clock,
    input  wire logic      reset,
    multdiv_ctrl_if.master bus
);

    state_e      r_state;
    state_e      w_state_next;
    logic        r_op_mult;
    logic [4:0]  r_rd;
    logic [31:0] r_opA;
    logic [31:0] r_opB;
    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_data;
    logic        r_wb_exc;

    logic w_req;
    logic w_terminal;
    logic w_done;
    logic w_stall;
    logic w_ctrl_mult;
    logic w_ctrl_div;
    logic w_wb_valid;

    assign w_req  = bus.ex_is_mult | bus.ex_is_div;
    // Ready has priority over the timeout when both land in the same cycle
    assign w_done = bus.md_resultRDY | w_terminal;

    md_timeout_counter #(
        .TIMEOUT (TIMEOUT),
        .WIDTH   (c_CNT_WIDTH)
    ) u_timeout (
        .clk        (clock),
        .rst        (reset),
        .i_clr      (r_state == ST_START),
        .i_en       (r_state == ST_BUSY),
        .o_terminal (w_terminal)
    );

    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        w_ctrl_mult  = 1'b0;
        w_ctrl_div   = 1'b0;
        w_wb_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_stall = w_req;
                if (w_req) w_state_next = ST_START;
            end
            ST_START: begin
                // resultRDY may still be high from the previous op; ignore it
                w_stall      = 1'b1;
                w_ctrl_mult  = r_op_mult;
                w_ctrl_div   = ~r_op_mult;
                w_state_next = ST_BUSY;
            end
            ST_BUSY: begin
                w_stall = 1'b1;
                if (w_done) w_state_next = ST_WB;
            end
            ST_WB: begin
                w_wb_valid   = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_op_mult <= 1'b0;
            r_rd      <= '0;
            r_opA     <= '0;
            r_opB     <= '0;
            r_wb_rd   <= '0;
            r_wb_data <= '0;
            r_wb_exc  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_IDLE && w_req) begin
                r_opA     <= bus.ex_opA;
                r_opB     <= bus.ex_opB;
                r_rd      <= bus.ex_rd;
                r_op_mult <= bus.ex_is_mult;
            end
            if (r_state == ST_BUSY && w_done) begin
                if (bus.md_resultRDY && !bus.md_exception) begin
                    r_wb_rd   <= r_rd;
                    r_wb_data <= bus.md_result;
                    r_wb_exc  <= 1'b0;
                end else begin
                    r_wb_rd   <= 5'(RSTATUS_REG);
                    r_wb_data <= r_op_mult ? 32'(MUL_EXC_CODE) : 32'(DIV_EXC_CODE);
                    r_wb_exc  <= 1'b1;
                end
            end
        end
    end

    assign bus.md_operandA  = r_opA;
    assign bus.md_operandB  = r_opB;
    assign bus.ctrl_MULT    = w_ctrl_mult & ~reset;
    assign bus.ctrl_DIV     = w_ctrl_div  & ~reset;
    assign bus.stall        = w_stall     & ~reset;
    assign bus.wb_valid     = w_wb_valid  & ~reset;
    assign bus.wb_rd        = r_wb_rd;
    assign bus.wb_data      = r_wb_data;
    assign bus.wb_exception = r_wb_exc;

endmodule
`default_nettype wire

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
- Processor-side sequencer that sits in the execute stage directly upstream of the multdiv unit.
- Captures a MUL/DIV instruction's operands and destination, then issues a single-cycle ctrl_MULT or ctrl_DIV pulse.
- Stalls the pipeline until data_resultRDY, then presents one writeback beat.
- On a multdiv exception, the writeback is redirected to $rstatus (r30) with the ISA status code.

Parameters:
- TIMEOUT, 40, maximum BUSY cycles before the operation is forced to complete with an exception
- RSTATUS_REG, 30, register index that receives exception status codes
- MUL_EXC_CODE, 4, value written to RSTATUS_REG on a mult exception
- DIV_EXC_CODE, 5, value written to RSTATUS_REG on a div exception

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- ex_is_mult  in  1  execute-stage instruction is MUL
- ex_is_div  in  1  execute-stage instruction is DIV
- ex_opA  in  32  operand A (rs)
- ex_opB  in  32  operand B (rt)
- ex_rd  in  5  destination register
- md_operandA  out  32  registered operand A to multdiv
- md_operandB  out  32  registered operand B to multdiv
- ctrl_MULT  out  1  one-cycle start pulse for multiply
- ctrl_DIV  out  1  one-cycle start pulse for divide
- md_result  in  32  multdiv data_result
- md_exception  in  1  multdiv data_exception
- md_resultRDY  in  1  multdiv data_resultRDY
- stall  out  1  freeze PC, F/D and D/X latches; bubble into X/M
- wb_valid  out  1  one-cycle writeback strobe
- wb_rd  out  5  writeback register
- wb_data  out  32  writeback data
- wb_exception  out  1  writeback is an exception status write

Behaviour:
- Reset (synchronous, sampled at the clock edge):
  - state=IDLE and the BUSY counter clears to 0.
  - All outputs are 0, including md_operandA/B, ctrl_*, stall and wb_*.
  - Reset mid-operation aborts the operation. No writeback occurs.
- States:
  - IDLE:
    - ex_is_mult|ex_is_div gives stall=1 combinationally.
    - At the clock edge, latch ex_opA/ex_opB into md_operandA/B, ex_rd into the internal rd, and the op type (mult=1). Go to START.
    - If both request bits are high, mult wins.
  - START:
    - ctrl_MULT or ctrl_DIV=1 for exactly this cycle; stall=1.
    - md_resultRDY is ignored because it may be stale from the previous op.
    - Counter cleared. Go to BUSY.
  - BUSY:
    - stall=1 and the counter increments.
    - md_resultRDY=1: capture md_result and md_exception, then go to WB.
    - Otherwise, counter==TIMEOUT-1: force exception=1, result=0, then go to WB.
    - RDY and timeout in the same cycle: RDY wins.
  - WB:
    - wb_valid=1 and stall=0, so the instruction advances.
    - ex_is_* are not sampled, so the departing instruction does not retrigger.
    - Go to IDLE.
- Writeback values:
  - Normal completion: wb_rd=captured rd, wb_data=result, wb_exception=0.
  - Exception: wb_rd=RSTATUS_REG, wb_data = MUL_EXC_CODE or DIV_EXC_CODE (zero-extended to 32 bits), wb_exception=1.
  - rd=0 with no exception: wb_valid still pulses with wb_rd=0; the regfile discards the write.
- wb_* hold their last values outside WB; only wb_valid qualifies them.
- md_operandA/B are stable from START through WB.
- Latency from request acceptance (IDLE edge) to wb_valid = 2 + N cycles, where N is the number of BUSY cycles up to and including RDY.
- Back-to-back ops: a new request is accepted in the IDLE cycle immediately after WB. The minimum gap is 1 cycle.
- ctrl_MULT and ctrl_DIV are never high together and never high outside START.

Decomposition:
- Shared package:
  - state encoding localparams (IDLE=0, START=1, BUSY=2, WB=3), 2 bits
  - RSTATUS_REG, MUL_EXC_CODE and DIV_EXC_CODE constants
- One natural sub-module: md_timeout_counter, a 6-bit synchronous counter with clear and enable, asserting a terminal flag at TIMEOUT-1.
- Operand, rd and result capture use the existing register primitives.

Test Plan:
- Mult 7*6 with rd=3, RDY after 5 BUSY cycles:
  - ctrl_MULT pulses once (1 cycle) and ctrl_DIV stays 0.
  - stall is high for 7 cycles.
  - Then wb_valid=1, wb_rd=3, wb_data=42, wb_exception=0.
- Div 100/0 with rd=9, RDY with md_exception=1:
  - wb_rd=30, wb_data=5, wb_exception=1.
  - The same case as a mult gives wb_data=4.
- Stale md_resultRDY=1 during START:
  - No transition to WB; the controller waits for RDY in BUSY.
  - wb_data equals the BUSY-cycle md_result.
- Back-to-back: mult then div with ex_is_div held high during WB:
  - No retrigger in the WB cycle.
  - The div is accepted in the next IDLE cycle and ctrl_DIV pulses 2 cycles after WB.
- Timeout: md_resultRDY never asserted on a div:
  - After 40 BUSY cycles, wb_valid=1, wb_rd=30, wb_data=5.
  - Stall drops in the WB cycle.
- reset asserted in BUSY:
  - The next cycle has state IDLE and stall=0.
  - No wb_valid is ever produced for the aborted op.
  - A later RDY in IDLE is ignored.
